// File: rtl/led_sequencer_pkg.sv
// Shared constants for the LED sequencer: switch mode encodings, FSM states
// and the pattern seeds loaded when a mode is entered.
package led_sequencer_pkg;

    localparam int PAT_W = 7;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CHASE  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [PAT_W-1:0] SEED_OFF    = 7'b0000000;
    localparam logic [PAT_W-1:0] SEED_CHASE  = 7'b0000001;
    localparam logic [PAT_W-1:0] SEED_BOUNCE = 7'b0000001;
    localparam logic [PAT_W-1:0] SEED_COUNT  = 7'b0000000;

    function automatic logic [PAT_W-1:0] seed_for(input mode_t mode);
        case (mode)
            MODE_CHASE:  seed_for = SEED_CHASE;
            MODE_BOUNCE: seed_for = SEED_BOUNCE;
            MODE_COUNT:  seed_for = SEED_COUNT;
            default:     seed_for = SEED_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_sequencer_switch_debounce.sv
// One switch bit: two-flop synchronizer followed by a debouncer that accepts
// a new level only after DEBOUNCE_LEN consecutive differing cycles.
module switch_debounce #(
    parameter int DEBOUNCE_LEN = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_LEN > 2) ? $clog2(DEBOUNCE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LEN - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            // Any cycle that agrees with the accepted level restarts the run.
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Switch-controlled 7-LED pattern generator: debounced mode/fast/pause inputs
// drive a LOAD/RUN FSM, a step tick counter and the pattern datapath.
module led_sequencer #(
    parameter int TICK_DIV     = 4000000,
    parameter int DEBOUNCE_LEN = 50000
) (
    input  logic       SYSTEMCLOCK,
    input  logic       RESET,
    input  logic [3:0] Switch_input,
    output logic [6:0] LED_output
);

    import led_sequencer_pkg::*;

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] LAST_SLOW = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] LAST_FAST = TICK_W'(TICK_DIV / 4 - 1);

    logic [3:0]        sw_deb;
    mode_t             deb_mode;
    logic              deb_fast;
    logic              deb_pause;

    state_t            state;
    mode_t             cur_mode;
    logic [PAT_W-1:0]  pattern;
    logic              dir_down;
    logic [TICK_W-1:0] tick;
    logic              fast_prev;

    logic [TICK_W-1:0] tick_last;
    logic              mode_change;
    logic              fast_change;
    logic [PAT_W-1:0]  next_pattern;
    logic              next_dir;

    for (genvar i = 0; i < 4; i++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_LEN(DEBOUNCE_LEN)
        ) u_deb (
            .clk   (SYSTEMCLOCK),
            .rst   (RESET),
            .raw   (Switch_input[i]),
            .stable(sw_deb[i])
        );
    end

    assign deb_mode    = mode_t'(sw_deb[1:0]);
    assign deb_fast    = sw_deb[2];
    assign deb_pause   = sw_deb[3];
    assign tick_last   = deb_fast ? LAST_FAST : LAST_SLOW;
    assign mode_change = (deb_mode != cur_mode);
    assign fast_change = (deb_fast != fast_prev);
    assign LED_output  = pattern;

    always_comb begin
        next_pattern = pattern;
        next_dir     = dir_down;
        case (cur_mode)
            MODE_CHASE: next_pattern = {pattern[PAT_W-2:0], pattern[PAT_W-1]};
            MODE_BOUNCE: begin
                // Reverse as soon as an endpoint is reached so it shows for one step.
                if (!dir_down) begin
                    next_pattern = pattern << 1;
                    if (next_pattern[PAT_W-1]) next_dir = 1'b1;
                end else begin
                    next_pattern = pattern >> 1;
                    if (next_pattern[0]) next_dir = 1'b0;
                end
            end
            MODE_COUNT: next_pattern = pattern + 1'b1;
            default:    next_pattern = SEED_OFF;
        endcase
    end

    always_ff @(posedge SYSTEMCLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_LOAD;
            cur_mode  <= MODE_OFF;
            pattern   <= '0;
            dir_down  <= 1'b0;
            tick      <= '0;
            fast_prev <= 1'b0;
        end else begin
            fast_prev <= deb_fast;
            case (state)
                ST_LOAD: begin
                    pattern  <= seed_for(deb_mode);
                    dir_down <= 1'b0;
                    tick     <= '0;
                    cur_mode <= deb_mode;
                    state    <= ST_RUN;
                end
                default: begin
                    // Priority: mode change, then speed change, then pause, then stepping.
                    if (mode_change) begin
                        state <= ST_LOAD;
                    end else if (fast_change) begin
                        tick <= '0;
                    end else if (!deb_pause) begin
                        if (tick == tick_last) begin
                            tick     <= '0;
                            pattern  <= next_pattern;
                            dir_down <= next_dir;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
